nibble_sequencer: RTL

//  Program buffer and playback stage directly upstream of stack_cpu. It stores a short

---
 rtl/nibble_sequencer_if.sv | 30 +++
 rtl/nibble_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sequencer_if.sv
// Purpose: bundles the program-load, playback-control and status signals of nibble_sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: none; writes outside IDLE or beyond capacity are dropped, not stalled.
// Ports: wr_en/wr_data/clear load the program, start/loop/abort control playback,
//   nib_out/busy/full/trunc_err/pc report back. master = driver side, slave = sequencer.
interface nibble_sequencer_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [3:0]    wr_data;
  logic          clear;
  logic          start;
  logic          loop;
  logic          abort;
  logic [3:0]    nib_out;
  logic          busy;
  logic          full;
  logic          trunc_err;
  logic [AW-1:0] pc;

  modport master (
    output wr_en, wr_data, clear, start, loop, abort,
    input  nib_out, busy, full, trunc_err, pc
  );

  modport slave (
    input  wr_en, wr_data, clear, start, loop, abort,
    output nib_out, busy, full, trunc_err, pc
  );
endinterface

// File: rtl/nibble_sequencer.sv
// Purpose: stores a nibble program and replays it into stack_cpu inbits, opcode then operands.
// Latency: opcode appears on nib_out one cycle after FETCH is entered (registered output).
// Backpressure: none; start is held pending until the CPU-phase launch slot, abort wins.
// Ports: clk, rst (sync, active-high, shared with stack_cpu), bus (slave modport of
//   nibble_sequencer_if). Memory contents survive rst; the program length does not.
module nibble_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  nibble_sequencer_if.slave   bus
);

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic        PH_F     = 1'b0;
  localparam logic        PH_E     = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  logic [3:0]  mem [DEPTH];

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic        pending_q, pending_d;
  logic        loop_q, loop_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  shadow_q, shadow_d;   // CPU exec cycles still running after an abort
  logic [AW:0] pc_q, pc_d;           // one extra bit so pc can equal a full length
  logic [AW:0] len_q, len_d;
  logic [3:0]  nib_q, nib_d;
  logic        trunc_q, trunc_d;
  logic        mem_we;

  logic [3:0]  rd_nib;
  logic        pc_ok;
  logic [AW:0] pc_inc;
  logic [AW:0] pc_after;
  logic        want_start;

  function automatic logic [1:0] exec_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_len = 2'd2;
      4'h9, 4'hA:                         exec_len = 2'd3;
      default:                            exec_len = 2'd1;
    endcase
  endfunction

  function automatic logic is_operand(input logic [3:0] op);
    is_operand = (op == 4'h1) || (op == 4'h6) || (op == 4'h7) || (op == 4'h8);
  endfunction

  assign rd_nib     = mem[pc_q[AW-1:0]];
  assign pc_ok      = (pc_q < len_q);
  assign pc_inc     = pc_q + 1'b1;
  // Operand ops consume their operand slot on the last exec cycle.
  assign pc_after   = is_operand(op_q) ? pc_inc : pc_q;
  assign want_start = pending_q | bus.start;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    loop_d    = loop_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    pc_d      = pc_q;
    len_d     = len_q;
    nib_d     = 4'h0;
    trunc_d   = trunc_q;
    mem_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          len_d   = '0;
          trunc_d = 1'b0;
        end else if (bus.wr_en && (len_q != FULL_LEN)) begin
          mem_we = 1'b1;
          len_d  = len_q + 1'b1;
        end
        // Mirror the CPU: either its NOOP fetch/exec toggle, or the tail of an
        // op that was still executing when playback was aborted.
        if (shadow_q != 2'd0) begin
          shadow_d = shadow_q - 2'd1;
          phase_d  = (shadow_q == 2'd1) ? PH_F : PH_E;
        end else begin
          phase_d  = ~phase_q;
        end
        pending_d = want_start && (len_q != '0);
        // Launch in the CPU's exec slot so the opcode lands in its next fetch.
        if (pending_d && (phase_q == PH_E) && (shadow_q == 2'd0)) begin
          state_d   = S_FETCH;
          pending_d = 1'b0;
          loop_d    = bus.loop;
          pc_d      = '0;
        end
      end
      S_FETCH: begin
        pending_d = want_start;
        nib_d     = rd_nib;
        op_d      = rd_nib;
        cnt_d     = exec_len(rd_nib);
        pc_d      = pc_inc;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        pending_d = want_start;
        if (is_operand(op_q)) begin
          if (pc_ok) begin
            nib_d = rd_nib;
          end else begin
            nib_d   = 4'h0;
            trunc_d = 1'b1;
          end
        end
        if (cnt_q == 2'd1) begin
          if (pc_after < len_q) begin
            state_d = S_FETCH;
            pc_d    = pc_after;
          end else if (loop_q) begin
            state_d = S_FETCH;
            pc_d    = '0;
          end else begin
            state_d = S_IDLE;
            pc_d    = '0;
            phase_d = PH_F;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) begin
      state_d   = S_IDLE;
      nib_d     = 4'h0;
      pc_d      = '0;
      pending_d = 1'b0;
      if (state_q == S_EXEC) begin
        trunc_d = trunc_q;
        if (cnt_q == 2'd1) begin
          phase_d  = PH_F;
          shadow_d = 2'd0;
        end else begin
          phase_d  = PH_E;
          shadow_d = cnt_q - 2'd1;
        end
      end else if (state_q == S_FETCH) begin
        // The opcode never reached the CPU, so it fetches a NOOP next.
        phase_d  = PH_F;
        shadow_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_F;
      pending_q <= 1'b0;
      loop_q    <= 1'b0;
      op_q      <= 4'h0;
      cnt_q     <= 2'd0;
      shadow_q  <= 2'd0;
      pc_q      <= '0;
      len_q     <= '0;
      nib_q     <= 4'h0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      loop_q    <= loop_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      nib_q     <= nib_d;
      trunc_q   <= trunc_d;
    end
  end

  // Program storage is deliberately not reset; only the length is.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[len_q[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.nib_out   = nib_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.full      = (len_q == FULL_LEN);
  assign bus.trunc_err = trunc_q;
  assign bus.pc        = pc_q[AW-1:0];

endmodule
